// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store unit with optional split of misaligned accesses
module load_store_unit #(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Access size in bytes from the low two funct3 bits.
  function automatic logic [3:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Doubleword and unsigned-word codes exist only on a 64-bit bus; unsigned codes never store.
  function automatic logic legal_of(input logic [2:0] f3, input logic st);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !st;
      3'b011:                 return (XLEN == 64);
      3'b110:                 return (XLEN == 64) && !st;
      default:                return 1'b0;
    endcase
  endfunction

  // True when the access runs past the end of its bus word.
  function automatic logic crosses(input logic [OFFW-1:0] off, input logic [3:0] sz);
    return ({1'b0, 4'(off)} + {1'b0, sz}) > 5'(NB);
  endfunction

  logic [1:0]      state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata0_q;
  logic [XLEN-1:0] result_q;
  logic [2:0]      funct3_q;
  logic            store_q;
  logic            mis_q;
  logic            fault_q;

  logic            acc_mis;
  logic            acc_fault;
  logic [OFFW-1:0] off_q;
  logic [3:0]      cur_size;
  logic [2*NB-1:0] mask_wide;
  logic [2*NB-1:0] be_wide;
  logic [2*XLEN-1:0] data_wide;
  logic [XLEN-1:0] rd_lo;
  logic [XLEN-1:0] rd_hi;
  logic [XLEN-1:0] raw;
  logic            sign_bit;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] load_result;
  logic [XLEN-1:0] base_addr;

  // Classify the incoming request so the accept cycle can pick fault or memory path.
  always_comb begin
    acc_mis   = crosses(addr[OFFW-1:0], size_of(funct3));
    acc_fault = !legal_of(funct3, req_store) || (acc_mis && !SPLIT_MISALIGNED);
  end

  // Store lane placement: size mask and data shifted into a two-word window by the byte offset.
  always_comb begin
    off_q     = addr_q[OFFW-1:0];
    cur_size  = size_of(funct3_q);
    mask_wide = '0;
    for (int i = 0; i < 2 * NB; i++) begin
      if (i < int'(cur_size)) mask_wide[i] = 1'b1;
    end
    be_wide   = mask_wide << off_q;
    data_wide = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
  end

  // Load assembly: beat0 bytes from the held copy (or the bus during BEAT0), beat1 bytes above them.
  always_comb begin
    rd_lo = (state == BEAT0) ? mem_rdata : rdata0_q;
    rd_hi = (state == BEAT1) ? mem_rdata : '0;
    raw   = XLEN'({rd_hi, rd_lo} >> {off_q, 3'b000});
    case (cur_size)
      4'd1:    sign_bit = raw[7];
      4'd2:    sign_bit = raw[15];
      4'd4:    sign_bit = raw[31];
      default: sign_bit = raw[XLEN-1];
    endcase
    ext = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < int'(cur_size) * 8) ext[i] = raw[i];
      else                        ext[i] = !funct3_q[2] && sign_bit;
    end
    load_result = store_q ? '0 : ext;
  end

  // Control FSM and latched request; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      result_q <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      mis_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            store_q  <= req_store;
            mis_q    <= acc_mis;
            fault_q  <= acc_fault;
            result_q <= '0;
            state    <= acc_fault ? RESP : BEAT0;
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            rdata0_q <= mem_rdata;
            if (mis_q) begin
              state <= BEAT1;
            end else begin
              result_q <= load_result;
              state    <= RESP;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            result_q <= load_result;
            state    <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus and response outputs decode from state so reset clears them without a clock.
  always_comb begin
    base_addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_fault = resp_valid && fault_q;
    resp_data  = resp_valid ? result_q : '0;
    mem_req    = (state == BEAT0) || (state == BEAT1);
    mem_we     = mem_req && store_q;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    if (state == BEAT0) begin
      mem_addr = base_addr;
      if (store_q) begin
        mem_be    = be_wide[NB-1:0];
        mem_wdata = data_wide[XLEN-1:0];
      end else begin
        mem_be = '1;
      end
    end else if (state == BEAT1) begin
      mem_addr = base_addr + XLEN'(NB);
      if (store_q) begin
        mem_be    = be_wide[2*NB-1:NB];
        mem_wdata = data_wide[2*XLEN-1:XLEN];
      end else begin
        mem_be = '1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Instance a: XLEN=32, split enabled
  logic        a_req_valid, a_req_ready, a_req_store, a_resp_valid, a_resp_fault;
  logic [2:0]  a_funct3;
  logic [31:0] a_addr, a_wdata, a_resp_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_mem_req, a_mem_we, a_mem_ready;
  logic [3:0]  a_mem_be;

  // Instance b: XLEN=32, split disabled
  logic        b_req_valid, b_req_ready, b_req_store, b_resp_valid, b_resp_fault;
  logic [2:0]  b_funct3;
  logic [31:0] b_addr, b_wdata, b_resp_data, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_req, b_mem_we, b_mem_ready;
  logic [3:0]  b_mem_be;

  // Instance c: XLEN=64, split enabled
  logic        c_req_valid, c_req_ready, c_req_store, c_resp_valid, c_resp_fault;
  logic [2:0]  c_funct3;
  logic [63:0] c_addr, c_wdata, c_resp_data, c_mem_addr, c_mem_wdata, c_mem_rdata;
  logic        c_mem_req, c_mem_we, c_mem_ready;
  logic [7:0]  c_mem_be;

  load_store_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_store(a_req_store), .funct3(a_funct3), .addr(a_addr), .wdata(a_wdata),
    .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_fault(a_resp_fault),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready)
  );

  load_store_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_store(b_req_store), .funct3(b_funct3), .addr(b_addr), .wdata(b_wdata),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_fault(b_resp_fault),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready)
  );

  load_store_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_store(c_req_store), .funct3(c_funct3), .addr(c_addr), .wdata(c_wdata),
    .resp_valid(c_resp_valid), .resp_data(c_resp_data), .resp_fault(c_resp_fault),
    .mem_req(c_mem_req), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_be(c_mem_be),
    .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata), .mem_ready(c_mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single-beat access on instance a, mem_ready on the first mem_req cycle.
  task automatic a_single(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    @(negedge clk);
    chk({tag, " ready"}, a_req_ready, 1'b1);
    a_req_valid = 1'b1; a_req_store = st; a_funct3 = f3; a_addr = ad; a_wdata = wd;
    @(negedge clk);
    a_req_valid = 1'b0; a_addr = 32'hFFFF_FFFF; a_wdata = 32'hDEAD_BEEF;
    chk({tag, " mem_req"}, a_mem_req, 1'b1);
    chk({tag, " mem_addr"}, a_mem_addr, exp_addr);
    chk({tag, " mem_we"}, a_mem_we, st);
    chk({tag, " mem_be"}, a_mem_be, exp_be);
    chk({tag, " mem_wdata"}, a_mem_wdata, exp_wdata);
    chk({tag, " early resp"}, a_resp_valid, 1'b0);
    a_mem_ready = 1'b1; a_mem_rdata = rd;
    @(negedge clk);
    a_mem_ready = 1'b0;
    chk({tag, " resp_valid"}, a_resp_valid, 1'b1);
    chk({tag, " resp_data"}, a_resp_data, exp_data);
    chk({tag, " resp_fault"}, a_resp_fault, 1'b0);
    chk({tag, " mem_req off"}, a_mem_req, 1'b0);
    @(negedge clk);
    chk({tag, " resp once"}, a_resp_valid, 1'b0);
  endtask

  // Request on instance b that must fault at T+1 without touching memory.
  task automatic b_fault(input string tag, input logic [2:0] f3, input logic [31:0] ad);
    @(negedge clk);
    chk({tag, " ready"}, b_req_ready, 1'b1);
    b_req_valid = 1'b1; b_req_store = 1'b0; b_funct3 = f3; b_addr = ad;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk({tag, " resp_valid"}, b_resp_valid, 1'b1);
    chk({tag, " resp_fault"}, b_resp_fault, 1'b1);
    chk({tag, " resp_data"}, b_resp_data, 32'h0);
    chk({tag, " no mem_req"}, b_mem_req, 1'b0);
    @(negedge clk);
    chk({tag, " resp once"}, b_resp_valid, 1'b0);
    chk({tag, " no mem_req after"}, b_mem_req, 1'b0);
  endtask

  // Aligned load on instance c.
  task automatic c_load(input string tag, input logic [2:0] f3, input logic [63:0] ad,
                        input logic [63:0] rd, input logic [63:0] exp_addr, input logic [63:0] exp_data);
    @(negedge clk);
    chk({tag, " ready"}, c_req_ready, 1'b1);
    c_req_valid = 1'b1; c_req_store = 1'b0; c_funct3 = f3; c_addr = ad;
    @(negedge clk);
    c_req_valid = 1'b0;
    chk({tag, " mem_addr"}, c_mem_addr, exp_addr);
    chk({tag, " mem_be"}, c_mem_be, 8'hFF);
    c_mem_ready = 1'b1; c_mem_rdata = rd;
    @(negedge clk);
    c_mem_ready = 1'b0;
    chk({tag, " resp_valid"}, c_resp_valid, 1'b1);
    chk({tag, " resp_data"}, c_resp_data, exp_data);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    a_req_valid = 0; a_req_store = 0; a_funct3 = 0; a_addr = 0; a_wdata = 0; a_mem_rdata = 0; a_mem_ready = 0;
    b_req_valid = 0; b_req_store = 0; b_funct3 = 0; b_addr = 0; b_wdata = 0; b_mem_rdata = 0; b_mem_ready = 0;
    c_req_valid = 0; c_req_store = 0; c_funct3 = 0; c_addr = 0; c_wdata = 0; c_mem_rdata = 0; c_mem_ready = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst req_ready", a_req_ready, 1'b1);
    chk("rst resp_valid", a_resp_valid, 1'b0);
    chk("rst mem_req", a_mem_req, 1'b0);
    chk("rst mem_be", a_mem_be, 4'h0);
    chk("rst mem_addr", a_mem_addr, 32'h0);
    chk("rst resp_data", a_resp_data, 32'h0);
    rst_n = 1'b1;

    // LB sign-extending, offset 3
    a_single("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 32'h100, 4'hF, 32'h0, 32'hFFFF_FF80);
    // LH sign-extending, offset 2 (ends exactly at word boundary)
    a_single("lh", 1'b0, 3'b001, 32'h002, 32'h0, 32'h8001_1234, 32'h000, 4'hF, 32'h0, 32'hFFFF_8001);
    // SH at offset 2, not split
    a_single("sh", 1'b1, 3'b001, 32'h002, 32'h0000_BEEF, 32'h0, 32'h000, 4'hC, 32'hBEEF_0000, 32'h0);

    // LHU split across words
    @(negedge clk);
    chk("lhu ready", a_req_ready, 1'b1);
    a_req_valid = 1'b1; a_req_store = 1'b0; a_funct3 = 3'b101; a_addr = 32'h203;
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("lhu b0 addr", a_mem_addr, 32'h200);
    chk("lhu b0 req", a_mem_req, 1'b1);
    a_mem_ready = 1'b1; a_mem_rdata = 32'hAB00_0000;
    @(negedge clk);
    chk("lhu b1 addr", a_mem_addr, 32'h204);
    chk("lhu b1 req", a_mem_req, 1'b1);
    chk("lhu b1 no resp", a_resp_valid, 1'b0);
    a_mem_rdata = 32'h0000_00CD;
    @(negedge clk);
    a_mem_ready = 1'b0;
    chk("lhu resp_valid", a_resp_valid, 1'b1);
    chk("lhu resp_data", a_resp_data, 32'h0000_CDAB);

    // SW split with one wait state on beat0
    @(negedge clk);
    a_req_valid = 1'b1; a_req_store = 1'b1; a_funct3 = 3'b010; a_addr = 32'h006; a_wdata = 32'h1122_3344;
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("sw b0 addr", a_mem_addr, 32'h004);
    chk("sw b0 be", a_mem_be, 4'hC);
    chk("sw b0 wdata", a_mem_wdata, 32'h3344_0000);
    chk("sw b0 we", a_mem_we, 1'b1);
    a_mem_ready = 1'b0;
    @(negedge clk);
    chk("sw wait addr", a_mem_addr, 32'h004);
    chk("sw wait be", a_mem_be, 4'hC);
    chk("sw wait req", a_mem_req, 1'b1);
    a_mem_ready = 1'b1;
    @(negedge clk);
    chk("sw b1 addr", a_mem_addr, 32'h008);
    chk("sw b1 be", a_mem_be, 4'h3);
    chk("sw b1 wdata", a_mem_wdata, 32'h0000_1122);
    @(negedge clk);
    a_mem_ready = 1'b0;
    chk("sw resp_valid", a_resp_valid, 1'b1);
    chk("sw resp_data", a_resp_data, 32'h0);
    chk("sw resp_fault", a_resp_fault, 1'b0);

    // Unsigned code with store is illegal
    @(negedge clk);
    a_req_valid = 1'b1; a_req_store = 1'b1; a_funct3 = 3'b100; a_addr = 32'h010;
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("sbu fault", a_resp_fault, 1'b1);
    chk("sbu resp_valid", a_resp_valid, 1'b1);
    chk("sbu no mem_req", a_mem_req, 1'b0);

    // mem_ready while idle is ignored
    @(negedge clk);
    a_mem_ready = 1'b1;
    @(negedge clk);
    chk("idle ready ignored resp", a_resp_valid, 1'b0);
    chk("idle ready ignored req", a_mem_req, 1'b0);
    a_mem_ready = 1'b0;

    // Asynchronous reset during a stalled BEAT0
    @(negedge clk);
    a_req_valid = 1'b1; a_req_store = 1'b0; a_funct3 = 3'b010; a_addr = 32'h010;
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("rstmid req before", a_mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid mem_req", a_mem_req, 1'b0);
    chk("rstmid req_ready", a_req_ready, 1'b1);
    chk("rstmid mem_addr", a_mem_addr, 32'h0);
    @(negedge clk);
    chk("rstmid no resp", a_resp_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid no resp after", a_resp_valid, 1'b0);
    a_single("sb post rst", 1'b1, 3'b000, 32'h021, 32'h0000_00A5, 32'h0, 32'h020, 4'h2, 32'h0000_A500, 32'h0);

    // Split disabled: misaligned and illegal both fault
    b_fault("lw mis", 3'b010, 32'h001);
    b_fault("f3 111", 3'b111, 32'h000);

    // 64-bit loads
    c_load("lwu64", 3'b110, 64'h4, 64'h8000_0001_1234_5678, 64'h0, 64'h0000_0000_8000_0001);
    c_load("lw64", 3'b010, 64'h4, 64'h8000_0001_1234_5678, 64'h0, 64'hFFFF_FFFF_8000_0001);
    c_load("ld64", 3'b011, 64'h10, 64'hFEDC_BA98_7654_3210, 64'h10, 64'hFEDC_BA98_7654_3210);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
